fifo_byte_packer: RTL and testbench

- Consumer ("read end") for the team's 8-bit FIFO1/FIFO2 instances.
- Drains bytes using the FIFO's EMPTY_N/DEQ/D_OUT protocol and packs them little-endian into BYTES_PER_WORD-byte words.
- Presents each word on a valid/ready output with a byte-enable mask. A flush request emits a partial word.
- Sits between a dut_wrapper FIFO output and wide downstream logic. Sustains 1 byte/cycle when the output is not stalled.

---
 rtl/fifo_pack_pkg.sv | 24 ++
 rtl/fifo_pack_outreg.sv | 63 ++++++
 rtl/fifo_byte_packer.sv | 144 ++++++++++++++
 tb/tb_fifo_byte_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared state type, widths and byte-enable helper for the byte packer
package fifo_pack_pkg;

  typedef enum logic [0:0] {
    ACCUM      = 1'b0,
    FLUSH_PEND = 1'b1
  } state_t;

  localparam int BYTE_W             = 8;
  localparam int MAX_BYTES_PER_WORD = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int WORD_W             = BYTE_W * DEF_BYTES_PER_WORD;

  // Low 'count' bits set, count in 0..MAX_BYTES_PER_WORD.
  function automatic logic [MAX_BYTES_PER_WORD-1:0] be_mask(input logic [3:0] count);
    logic [MAX_BYTES_PER_WORD-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES_PER_WORD; i++) begin
      m[i] = (4'(i) < count);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_pack_outreg.sv
// rtl/fifo_pack_outreg.sv - output word holding register with valid/ready handshake and accepted-word counter
module fifo_pack_outreg
  import fifo_pack_pkg::*;
#(
  parameter int P_WORD_W = 32,
  parameter int P_BE_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [P_WORD_W-1:0] i_word,
  input  logic [P_BE_W-1:0]   i_be,
  input  logic                i_rdy,
  output logic                o_valid,
  output logic [P_WORD_W-1:0] o_word,
  output logic [P_BE_W-1:0]   o_be,
  output logic [CNT_W-1:0]    o_cnt,
  output logic                o_free
);

  logic                r_valid;
  logic [P_WORD_W-1:0] r_word;
  logic [P_BE_W-1:0]   r_be;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept;

  assign w_accept = r_valid && i_rdy;
  assign o_free   = !r_valid || i_rdy;

  // i_load is only raised by the packer while o_free is high, so a load never drops a held word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_load) begin
        r_valid <= 1'b1;
        r_word  <= i_word;
        r_be    <= i_be;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;
  assign o_be    = r_be;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - drains an 8-bit FIFO and packs bytes little-endian into words with flush support
module fifo_byte_packer
  import fifo_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clr,
  input  logic                             i_fifo_empty_n,
  input  logic [BYTE_W-1:0]                i_fifo_d_out,
  output logic                             o_fifo_deq,
  input  logic                             i_flush,
  output logic                             o_word_valid,
  input  logic                             i_word_rdy,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] o_word_out,
  output logic [BYTES_PER_WORD-1:0]        o_word_be,
  output logic [CNT_W-1:0]                 o_word_cnt,
  output logic                             o_busy
);

  localparam int P_WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int FILL_W   = $clog2(BYTES_PER_WORD);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [P_WORD_W-1:0]       r_acc;
  logic [P_WORD_W-1:0]       w_acc_nxt;
  logic [P_WORD_W-1:0]       w_acc_ins;
  logic [FILL_W-1:0]         r_fill;
  logic [FILL_W-1:0]         w_fill_nxt;
  logic [FILL_W:0]           w_count;
  logic                      w_fill_last;
  logic                      w_free;
  logic                      w_deq;
  logic                      w_load;
  logic [P_WORD_W-1:0]       w_load_word;
  logic [BYTES_PER_WORD-1:0] w_load_be;

  assign w_fill_last = (r_fill == FILL_W'(BYTES_PER_WORD - 1));

  // The last byte of a word may only be popped when the output register can take the word.
  assign w_deq = i_rst_n && !i_clr && i_fifo_empty_n && (r_state == ACCUM) &&
                 !(w_fill_last && !w_free);

  assign w_count = {1'b0, r_fill} + {{FILL_W{1'b0}}, w_deq};

  always_comb begin
    w_acc_ins = r_acc;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (w_deq && (r_fill == FILL_W'(i))) begin
        w_acc_ins[i*BYTE_W +: BYTE_W] = i_fifo_d_out;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_fill_nxt  = r_fill;
    w_load      = 1'b0;
    w_load_word = r_acc;
    w_load_be   = '0;
    case (r_state)
      ACCUM: begin
        if (w_deq && w_fill_last) begin
          w_load      = 1'b1;
          w_load_word = w_acc_ins;
          w_load_be   = '1;
          w_acc_nxt   = '0;
          w_fill_nxt  = '0;
        end else if (i_flush && (w_count != '0)) begin
          if (w_free) begin
            w_load      = 1'b1;
            w_load_word = w_acc_ins;
            w_load_be   = BYTES_PER_WORD'(be_mask(4'(w_count)));
            w_acc_nxt   = '0;
            w_fill_nxt  = '0;
          end else begin
            w_acc_nxt   = w_acc_ins;
            w_fill_nxt  = FILL_W'(w_count);
            w_state_nxt = FLUSH_PEND;
          end
        end else begin
          w_acc_nxt  = w_acc_ins;
          w_fill_nxt = FILL_W'(w_count);
        end
      end
      FLUSH_PEND: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_word = r_acc;
          w_load_be   = BYTES_PER_WORD'(be_mask(4'(r_fill)));
          w_acc_nxt   = '0;
          w_fill_nxt  = '0;
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_fill  <= '0;
    end else if (i_clr) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  fifo_pack_outreg #(
    .P_WORD_W (P_WORD_W),
    .P_BE_W   (BYTES_PER_WORD),
    .CNT_W    (CNT_W)
  ) u_outreg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_load  (w_load),
    .i_word  (w_load_word),
    .i_be    (w_load_be),
    .i_rdy   (i_word_rdy),
    .o_valid (o_word_valid),
    .o_word  (o_word_out),
    .o_be    (o_word_be),
    .o_cnt   (o_word_cnt),
    .o_free  (w_free)
  );

  assign o_fifo_deq = w_deq;
  assign o_busy     = (r_fill != '0) || (r_state == FLUSH_PEND);

endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb/tb_fifo_byte_packer.sv - directed self-checking bench for fifo_byte_packer (4-byte words, 4-bit word counter)
module tb_fifo_byte_packer;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        fifo_empty_n;
  logic [7:0]  fifo_d_out;
  logic        fifo_deq;
  logic        flush;
  logic        word_valid;
  logic        word_rdy;
  logic [31:0] word_out;
  logic [3:0]  word_be;
  logic [3:0]  word_cnt;
  logic        busy;

  logic [7:0]  q_src[$];
  logic [35:0] q_out[$];
  int          n_assert;
  int          n_fail;
  int          n_deq;
  int          n_bad_deq;
  int          deq_base;

  fifo_byte_packer #(
    .BYTES_PER_WORD (4),
    .CNT_W          (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_clr          (clr),
    .i_fifo_empty_n (fifo_empty_n),
    .i_fifo_d_out   (fifo_d_out),
    .o_fifo_deq     (fifo_deq),
    .i_flush        (flush),
    .o_word_valid   (word_valid),
    .i_word_rdy     (word_rdy),
    .o_word_out     (word_out),
    .o_word_be      (word_be),
    .o_word_cnt     (word_cnt),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] out_at(input int k);
    if (k < q_out.size()) return q_out[k];
    return 36'h0;
  endfunction

  task automatic src_update();
    fifo_empty_n = (q_src.size() != 0);
    fifo_d_out   = (q_src.size() != 0) ? q_src[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q_src.push_back(b);
    src_update();
  endtask

  // One clock: sample handshakes at the falling edge, model the source FIFO pop after the rising edge.
  task automatic cycle();
    logic d;
    @(negedge clk);
    d = fifo_deq;
    if (d && !fifo_empty_n) n_bad_deq++;
    if (word_valid && word_rdy) q_out.push_back({word_be, word_out});
    @(posedge clk);
    #1;
    if (d && (q_src.size() != 0)) begin
      void'(q_src.pop_front());
      n_deq++;
    end
    src_update();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; n_deq = 0; n_bad_deq = 0;
    rst_n = 1'b0; clr = 1'b0; flush = 1'b0; word_rdy = 1'b0;
    src_update();

    // Reset state, with data waiting in the source
    for (int k = 1; k <= 8; k++) push(8'(k * 8'h11));
    #1;
    chk("rst_deq", 64'(fifo_deq), 64'd0);
    cycles(2);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_word", 64'(word_out), 64'd0);
    chk("rst_be", 64'(word_be), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_no_pop", 64'(n_deq), 64'd0);

    // Full words, no stall
    rst_n = 1'b1;
    word_rdy = 1'b1;
    cycles(3);
    chk("full_pre_valid", 64'(word_valid), 64'd0);
    chk("full_pre_busy", 64'(busy), 64'd1);
    cycle();
    chk("full_w1_valid", 64'(word_valid), 64'd1);
    chk("full_w1_word", 64'(word_out), 64'h44332211);
    chk("full_w1_be", 64'(word_be), 64'hF);
    cycles(6);
    chk("full_nwords", 64'(q_out.size()), 64'd2);
    chk("full_q0", 64'(out_at(0)), 64'hF44332211);
    chk("full_q1", 64'(out_at(1)), 64'hF88776655);
    chk("full_cnt", 64'(word_cnt), 64'd2);
    chk("full_busy", 64'(busy), 64'd0);

    // Partial flush one cycle after the last pop
    q_out.delete();
    push(8'hA1); push(8'hB2); push(8'hC3);
    cycles(3);
    chk("pf_busy", 64'(busy), 64'd1);
    pulse_flush();
    chk("pf_valid", 64'(word_valid), 64'd1);
    chk("pf_word", 64'(word_out), 64'h00C3B2A1);
    chk("pf_be", 64'(word_be), 64'h7);
    chk("pf_busy_fall", 64'(busy), 64'd0);
    cycle();
    chk("pf_cnt", 64'(word_cnt), 64'd3);

    // Back-pressure: 9 bytes, ready low for 10 cycles
    q_out.delete();
    word_rdy = 1'b0;
    deq_base = n_deq;
    for (int k = 1; k <= 9; k++) push(8'(k));
    cycles(10);
    chk("bp_popped", 64'(n_deq - deq_base), 64'd7);
    chk("bp_deq_held", 64'(fifo_deq), 64'd0);
    chk("bp_hold_word", 64'(word_out), 64'h04030201);
    chk("bp_hold_be", 64'(word_be), 64'hF);
    chk("bp_src_left", 64'(q_src.size()), 64'd2);
    word_rdy = 1'b1;
    cycles(2);
    pulse_flush();
    cycle();
    chk("bp_nwords", 64'(q_out.size()), 64'd3);
    chk("bp_q0", 64'(out_at(0)), 64'hF04030201);
    chk("bp_q1", 64'(out_at(1)), 64'hF08070605);
    chk("bp_q2", 64'(out_at(2)), 64'h100000009);
    chk("bp_cnt", 64'(word_cnt), 64'd6);

    // Flush while the output is stalled with two bytes pending
    q_out.delete();
    word_rdy = 1'b0;
    for (int k = 1; k <= 6; k++) push(8'(8'h20 + k));
    cycles(7);
    pulse_flush();
    push(8'h27);
    #1;
    chk("fp_deq_blocked", 64'(fifo_deq), 64'd0);
    chk("fp_busy", 64'(busy), 64'd1);
    pulse_flush();
    chk("fp_src_kept", 64'(q_src.size()), 64'd1);
    word_rdy = 1'b1;
    cycle();
    chk("fp_part_word", 64'(word_out), 64'h00002625);
    chk("fp_part_be", 64'(word_be), 64'h3);
    cycle();
    pulse_flush();
    cycle();
    chk("fp_nwords", 64'(q_out.size()), 64'd3);
    chk("fp_q0", 64'(out_at(0)), 64'hF24232221);
    chk("fp_q1", 64'(out_at(1)), 64'h300002625);
    chk("fp_q2", 64'(out_at(2)), 64'h100000027);
    chk("fp_cnt", 64'(word_cnt), 64'd9);

    // Asynchronous reset mid-word
    push(8'h31); push(8'h32); push(8'h33);
    cycles(3);
    chk("ar_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_cnt", 64'(word_cnt), 64'd0);
    chk("ar_word", 64'(word_out), 64'd0);
    deq_base = n_deq;
    for (int k = 1; k <= 4; k++) push(8'(8'h40 + k));
    cycles(2);
    chk("ar_no_pop", 64'(n_deq - deq_base), 64'd0);
    rst_n = 1'b1;
    cycles(4);
    chk("ar_clean_word", 64'(word_out), 64'h44434241);
    chk("ar_clean_be", 64'(word_be), 64'hF);
    cycle();
    chk("ar_cnt_after", 64'(word_cnt), 64'd1);

    // Synchronous clear with a held word and three pending bytes
    word_rdy = 1'b0;
    for (int k = 1; k <= 7; k++) push(8'(8'h50 + k));
    cycles(8);
    chk("cl_held", 64'(word_valid), 64'd1);
    clr = 1'b1;
    for (int k = 1; k <= 4; k++) push(8'(8'h60 + k));
    #1;
    chk("cl_deq_gated", 64'(fifo_deq), 64'd0);
    chk("cl_cnt_pre_edge", 64'(word_cnt), 64'd1);
    cycle();
    clr = 1'b0;
    chk("cl_valid", 64'(word_valid), 64'd0);
    chk("cl_busy", 64'(busy), 64'd0);
    chk("cl_cnt", 64'(word_cnt), 64'd0);
    chk("cl_word", 64'(word_out), 64'd0);
    word_rdy = 1'b1;
    cycles(4);
    chk("cl_clean_word", 64'(word_out), 64'h64636261);
    cycle();
    chk("cl_cnt_after", 64'(word_cnt), 64'd1);

    // Flush in the same cycle that completes a word
    q_out.delete();
    for (int k = 1; k <= 4; k++) push(8'(8'h70 + k));
    cycles(3);
    pulse_flush();
    cycles(3);
    chk("ff_nwords", 64'(q_out.size()), 64'd1);
    chk("ff_q0", 64'(out_at(0)), 64'hF74737271);
    chk("ff_busy", 64'(busy), 64'd0);

    // Flush with nothing held
    pulse_flush();
    cycles(2);
    chk("fe_nwords", 64'(q_out.size()), 64'd1);
    chk("fe_valid", 64'(word_valid), 64'd0);
    chk("fe_cnt", 64'(word_cnt), 64'd2);

    // Counter wrap: 17 accepted words on a 4-bit counter
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    q_out.delete();
    for (int k = 0; k < 68; k++) push(8'(k));
    cycles(72);
    chk("wr_nwords", 64'(q_out.size()), 64'd17);
    chk("wr_first", 64'(out_at(0)), 64'hF03020100);
    chk("wr_last", 64'(out_at(16)), 64'hF43424140);
    chk("wr_cnt", 64'(word_cnt), 64'd1);
    chk("idle_deq", 64'(fifo_deq), 64'd0);
    chk("deq_when_empty", 64'(n_bad_deq), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
